// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding definitions: format codes, opcodes, NOP word and the
// FIFO entry layout used by the instruction encoder and its consumers.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_J = 3'd1,
        FMT_U = 3'd2,
        FMT_S = 3'd3,
        FMT_B = 3'd4,
        FMT_I = 3'd5
    } fmt_e;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } enc_entry_t;

    // True when imm is representable as a BITS-wide two's-complement value.
    function automatic logic fits_signed(input logic [31:0] imm, input int unsigned bits);
        logic [31:0] sh;
        sh = $signed(imm) >>> (bits - 1);
        return (sh == '0) || (sh == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-input and instruction-output handshake bundle of the encoder.
interface instr_encoder_if;

    logic        in_valid_w_i;
    logic        in_ready_w_o;
    logic [2:0]  type_w_i;
    logic [6:0]  opcode_w_i;
    logic [4:0]  rd_w_i;
    logic [4:0]  rs1_w_i;
    logic [4:0]  rs2_w_i;
    logic [2:0]  funct3_w_i;
    logic [6:0]  funct7_w_i;
    logic [31:0] imm_w_i;
    logic        out_valid_w_o;
    logic        out_ready_w_i;
    logic [31:0] instr_w_o;
    logic        err_w_o;

    modport master (
        output in_valid_w_i, type_w_i, opcode_w_i, rd_w_i, rs1_w_i, rs2_w_i,
               funct3_w_i, funct7_w_i, imm_w_i, out_ready_w_i,
        input  in_ready_w_o, out_valid_w_o, instr_w_o, err_w_o
    );

    modport slave (
        input  in_valid_w_i, type_w_i, opcode_w_i, rd_w_i, rs1_w_i, rs2_w_i,
               funct3_w_i, funct7_w_i, imm_w_i, out_ready_w_i,
        output in_ready_w_o, out_valid_w_o, instr_w_o, err_w_o
    );

endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Synchronous FIFO with power-of-two depth, synchronous flush and a
// combinational head read; storage is cleared on reset so the head reads zero.
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I field-to-instruction encoder: packs format/register/immediate fields
// into an instruction word, flags range/alignment/type errors, buffers in a FIFO.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk_w_i,
    input  logic              rst_n_w_i,
    input  logic              flush_w_i,
    instr_encoder_if.slave    bus,
    output logic [CNT_W-1:0]  enc_count_w_o,
    output logic [CNT_W-1:0]  err_count_w_o
);

    logic             rdy_q;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic [31:0]      imm;
    logic [31:0]      enc_instr;
    logic             enc_err;
    enc_entry_t       wr_entry, rd_entry;
    logic [CNT_W-1:0] enc_cnt_q, err_cnt_q;

    // Ready is held low until the first edge after reset release.
    always_ff @(posedge clk_w_i or negedge rst_n_w_i) begin
        if (!rst_n_w_i) rdy_q <= 1'b0;
        else            rdy_q <= 1'b1;
    end

    assign bus.in_ready_w_o = rdy_q & ~fifo_full & ~flush_w_i;
    assign push             = bus.in_valid_w_i & bus.in_ready_w_o;
    assign imm              = bus.imm_w_i;

    always_comb begin
        enc_instr = INSTR_NOP;
        enc_err   = 1'b1;
        case (bus.type_w_i)
            FMT_R: begin
                enc_instr = {bus.funct7_w_i, bus.rs2_w_i, bus.rs1_w_i, bus.funct3_w_i,
                             bus.rd_w_i, bus.opcode_w_i};
                enc_err   = 1'b0;
            end
            FMT_I: begin
                enc_instr = {imm[11:0], bus.rs1_w_i, bus.funct3_w_i, bus.rd_w_i, bus.opcode_w_i};
                enc_err   = ~fits_signed(imm, 12);
            end
            FMT_S: begin
                enc_instr = {imm[11:5], bus.rs2_w_i, bus.rs1_w_i, bus.funct3_w_i,
                             imm[4:0], bus.opcode_w_i};
                enc_err   = ~fits_signed(imm, 12);
            end
            FMT_B: begin
                enc_instr = {imm[12], imm[10:5], bus.rs2_w_i, bus.rs1_w_i, bus.funct3_w_i,
                             imm[4:1], imm[11], bus.opcode_w_i};
                enc_err   = ~fits_signed(imm, 13) | imm[0];
            end
            FMT_U: begin
                enc_instr = {imm[31:12], bus.rd_w_i, bus.opcode_w_i};
                enc_err   = (imm[11:0] != '0);
            end
            FMT_J: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_w_i, bus.opcode_w_i};
                enc_err   = ~fits_signed(imm, 21) | imm[0];
            end
            default: begin
                enc_instr = INSTR_NOP;
                enc_err   = 1'b1;
            end
        endcase
    end

    assign wr_entry = '{err: enc_err, instr: enc_instr};

    sync_fifo #(
        .WIDTH ($bits(enc_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_w_i),
        .rst_n_i (rst_n_w_i),
        .flush_i (flush_w_i),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.out_valid_w_o = ~fifo_empty;
    assign bus.instr_w_o     = rd_entry.instr;
    assign bus.err_w_o       = rd_entry.err;
    assign pop               = bus.out_valid_w_o & bus.out_ready_w_i;

    always_ff @(posedge clk_w_i or negedge rst_n_w_i) begin
        if (!rst_n_w_i) begin
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (push) begin
            if (enc_cnt_q != '1)            enc_cnt_q <= enc_cnt_q + CNT_W'(1);
            if (enc_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign enc_count_w_o = enc_cnt_q;
    assign err_count_w_o = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, handshake
// corner sequences and a randomized run against a decode-back reference model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 4;
    localparam int          N_RAND = 10000;

    typedef struct packed {
        logic [2:0]  typ;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    typedef struct packed {
        fields_t     f;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7, op;
    } view_t;

    typedef struct packed {
        fields_t f;
        logic    err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] enc_cnt, err_cnt;
    int               n_cmp = 0;
    int               n_bad = 0;

    instr_encoder_if bus ();

    instr_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_w_i       (clk),
        .rst_n_w_i     (rst_n),
        .flush_w_i     (flush),
        .bus           (bus),
        .enc_count_w_o (enc_cnt),
        .err_count_w_o (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input fields_t f, input logic v);
        bus.in_valid_w_i = v;
        bus.type_w_i     = f.typ;
        bus.opcode_w_i   = f.op;
        bus.rd_w_i       = f.rd;
        bus.rs1_w_i      = f.rs1;
        bus.rs2_w_i      = f.rs2;
        bus.funct3_w_i   = f.f3;
        bus.funct7_w_i   = f.f7;
        bus.imm_w_i      = f.imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid_w_i  = 1'b0;
        bus.out_ready_w_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic vec_t mk(input logic [2:0] typ, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] ei, input logic ee);
        vec_t v;
        v.f = '{typ: typ, op: op, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: f7, imm: imm};
        v.exp_instr = ei;
        v.exp_err   = ee;
        return v;
    endfunction

    // Keep only the fields that the given format actually carries.
    function automatic view_t keep(input logic [2:0] typ, input view_t v);
        view_t r = v;
        case (typ)
            3'd0: r.imm = '0;
            3'd5: begin r.rs2 = '0; r.f7 = '0; end
            3'd3, 3'd4: begin r.rd = '0; r.f7 = '0; end
            default: begin r.rs1 = '0; r.rs2 = '0; r.f3 = '0; r.f7 = '0; end
        endcase
        return r;
    endfunction

    // imm_gen-style decode of an instruction word back into fields.
    function automatic view_t decode(input logic [2:0] typ, input logic [31:0] w);
        view_t v;
        v.op = w[6:0]; v.rd = w[11:7]; v.f3 = w[14:12];
        v.rs1 = w[19:15]; v.rs2 = w[24:20]; v.f7 = w[31:25];
        case (typ)
            3'd5:    v.imm = {{20{w[31]}}, w[31:20]};
            3'd3:    v.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            3'd4:    v.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd2:    v.imm = {w[31:12], 12'b0};
            3'd1:    v.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: v.imm = '0;
        endcase
        return keep(typ, v);
    endfunction

    // Expected decoded view: immediate wrapped to the format's field width.
    function automatic view_t expect_view(input fields_t f);
        view_t v;
        int    s;
        s = 0;
        case (f.typ)
            3'd5, 3'd3: begin s = int'(f.imm & 32'hFFF);      if (s >= 2048)    s -= 4096;    end
            3'd4:       begin s = int'(f.imm & 32'h1FFE);     if (s >= 4096)    s -= 8192;    end
            3'd1:       begin s = int'(f.imm & 32'h1F_FFFE);  if (s >= 1 << 20) s -= 1 << 21; end
            3'd2:       s = int'(f.imm & 32'hFFFF_F000);
            default:    s = 0;
        endcase
        v = '{imm: s, rd: f.rd, rs1: f.rs1, rs2: f.rs2, f3: f.f3, f7: f.f7, op: f.op};
        return keep(f.typ, v);
    endfunction

    function automatic logic expect_err(input fields_t f);
        int s;
        s = int'(f.imm);
        case (f.typ)
            3'd0:       return 1'b0;
            3'd5, 3'd3: return !(s >= -2048 && s <= 2047);
            3'd4:       return !(s >= -4096 && s <= 4095) || (s % 2 != 0);
            3'd1:       return !(s >= -(1 << 20) && s <= (1 << 20) - 1) || (s % 2 != 0);
            3'd2:       return (f.imm % 4096) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic fields_t gen();
        fields_t f;
        f.typ = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        f.op  = 7'($urandom);
        f.rd  = 5'($urandom);
        f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom);
        f.f3  = 3'($urandom);
        f.f7  = 7'($urandom);
        case ($urandom_range(0, 3))
            0:       f.imm = $urandom;
            1:       f.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       f.imm = 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
            default: f.imm = $urandom & 32'hFFFF_F000;
        endcase
        if ($urandom_range(0, 1) == 1) f.imm[0] = 1'b0;
        return f;
    endfunction

    vec_t tbl[15];
    exp_t q[$];

    initial begin
        fields_t cur;
        exp_t    e;
        logic    have;
        int      done, cyc, enc_m, err_m;

        tbl[0]  = mk(3'd5, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        tbl[1]  = mk(3'd3, OPC_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020_A423, 1'b0);
        tbl[2]  = mk(3'd2, OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
        tbl[3]  = mk(3'd1, OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,        32'h0010_00EF, 1'b0);
        tbl[4]  = mk(3'd4, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,          32'h0020_8163, 1'b1);
        tbl[5]  = mk(3'd5, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h8000_0093, 1'b1);
        tbl[6]  = mk(3'd7, OPC_OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h1234,       INSTR_NOP,     1'b1);
        tbl[7]  = mk(3'd0, OPC_OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF,  32'h0020_81B3, 1'b0);
        tbl[8]  = mk(3'd2, OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,          32'h0000_02B7, 1'b1);
        tbl[9]  = mk(3'd1, OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC,  32'hFFDF_F0EF, 1'b0);
        tbl[10] = mk(3'd3, OPC_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFF,  32'hFE20_AFA3, 1'b0);
        tbl[11] = mk(3'd4, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFF_F000,  32'h8020_9063, 1'b0);
        tbl[12] = mk(3'd4, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'h0000_1000,  32'h8020_9063, 1'b1);
        tbl[13] = mk(3'd5, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,  32'h8000_0093, 1'b0);
        tbl[14] = mk(3'd6, OPC_LOAD,   5'd4, 5'd4, 5'd4, 3'd2, 7'd0, 32'd0,          INSTR_NOP,     1'b1);

        drive(tbl[0].f, 1'b0);
        bus.out_ready_w_i = 1'b0;

        // Reset values while reset is asserted.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  bus.in_ready_w_o, 0);
        chk("rst_out_valid", bus.out_valid_w_o, 0);
        chk("rst_instr",     bus.instr_w_o, 0);
        chk("rst_err",       bus.err_w_o, 0);
        chk("rst_enc_cnt",   enc_cnt, 0);
        chk("rst_err_cnt",   err_cnt, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", bus.in_ready_w_o, 0);
        tick();
        chk("ready_after_edge", bus.in_ready_w_o, 1);

        // Directed vector table: push one, check it one edge later, pop it.
        bus.out_ready_w_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].f, 1'b1);
            @(negedge clk);
            chk("tbl_in_ready", bus.in_ready_w_o, 1);
            tick();
            bus.in_valid_w_i = 1'b0;
            chk($sformatf("tbl%0d_valid", i), bus.out_valid_w_o, 1);
            chk($sformatf("tbl%0d_instr", i), bus.instr_w_o, tbl[i].exp_instr);
            chk($sformatf("tbl%0d_err", i),   bus.err_w_o, tbl[i].exp_err);
            tick();
        end
        chk("tbl_drained", bus.out_valid_w_o, 0);
        chk("tbl_enc_cnt", enc_cnt, 15);
        chk("tbl_err_cnt", err_cnt, 6);

        // Back-pressure: third push held while full, order preserved on release.
        do_reset();
        bus.out_ready_w_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(tbl[(c < 2) ? c : 2].f, 1'b1);
            @(negedge clk);
            chk($sformatf("bp_ready_c%0d", c), bus.in_ready_w_o, (c < 2) ? 1 : 0);
            if (c >= 1) chk($sformatf("bp_stable_c%0d", c), bus.instr_w_o, tbl[0].exp_instr);
            tick();
        end
        bus.out_ready_w_i = 1'b1;
        @(negedge clk);
        chk("bp_pop0", bus.instr_w_o, tbl[0].exp_instr);
        chk("bp_full_ready", bus.in_ready_w_o, 0);
        tick();
        @(negedge clk);
        chk("bp_pop1", bus.instr_w_o, tbl[1].exp_instr);
        chk("bp_pushpop_ready", bus.in_ready_w_o, 1);
        tick();
        bus.in_valid_w_i = 1'b0;
        @(negedge clk);
        chk("bp_pop2_valid", bus.out_valid_w_o, 1);
        chk("bp_pop2", bus.instr_w_o, tbl[2].exp_instr);
        tick();
        @(negedge clk);
        chk("bp_empty", bus.out_valid_w_o, 0);
        chk("bp_enc_cnt", enc_cnt, 3);

        // Asynchronous reset with two entries queued.
        tick();
        bus.out_ready_w_i = 1'b0;
        drive(tbl[4].f, 1'b1); tick();
        drive(tbl[0].f, 1'b1); tick();
        bus.in_valid_w_i = 1'b0;
        chk("mid_valid_pre", bus.out_valid_w_o, 1);
        chk("mid_err_cnt_pre", err_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", bus.out_valid_w_o, 0);
        chk("mid_enc_cnt", enc_cnt, 0);
        chk("mid_err_cnt", err_cnt, 0);
        chk("mid_ready", bus.in_ready_w_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Flush with two queued and a same-cycle push that must be dropped.
        drive(tbl[4].f, 1'b1); tick();
        drive(tbl[0].f, 1'b1); tick();
        drive(tbl[1].f, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", bus.in_ready_w_o, 0);
        tick();
        flush = 1'b0;
        bus.in_valid_w_i = 1'b0;
        chk("flush_empty", bus.out_valid_w_o, 0);
        chk("flush_enc_cnt", enc_cnt, 2);
        chk("flush_err_cnt", err_cnt, 1);
        drive(tbl[2].f, 1'b1); tick();
        bus.in_valid_w_i = 1'b0;
        chk("post_flush_head", bus.instr_w_o, tbl[2].exp_instr);
        bus.out_ready_w_i = 1'b1;
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        have = 1'b0; done = 0; cyc = 0; enc_m = 0; err_m = 0;
        while (done < N_RAND && cyc < 80000) begin
            if (!have) begin
                cur  = gen();
                have = 1'b1;
            end
            drive(cur, $urandom_range(0, 3) != 0);
            bus.out_ready_w_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rnd_out_valid", bus.out_valid_w_o, (q.size() != 0) ? 1 : 0);
            chk("rnd_in_ready",  bus.in_ready_w_o, (q.size() < DEPTH) ? 1 : 0);
            if (bus.out_valid_w_o && bus.out_ready_w_i && q.size() > 0) begin
                e = q.pop_front();
                chk("rnd_err", bus.err_w_o, e.err);
                if (e.f.typ > 3'd5) chk("rnd_nop", bus.instr_w_o, INSTR_NOP);
                else chk("rnd_fields", decode(e.f.typ, bus.instr_w_o), expect_view(e.f));
                done++;
            end
            if (bus.in_valid_w_i && bus.in_ready_w_o) begin
                e.f   = cur;
                e.err = expect_err(cur);
                q.push_back(e);
                enc_m++;
                if (e.err) err_m++;
                have = 1'b0;
            end
            tick();
            cyc++;
        end
        chk("rnd_done", done, N_RAND);
        chk("rnd_enc_sat", enc_cnt, (enc_m > 15) ? 15 : enc_m);
        chk("rnd_err_sat", err_cnt, (err_m > 15) ? 15 : err_m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Field-to-instruction encoder: the inverse of imm_gen. It accepts RV32I instruction fields (format type, opcode, registers, funct, 32-bit immediate) over a valid/ready handshake. It packs them into a 32-bit instruction word and buffers the result in a small output FIFO. It feeds the boot/test instruction-memory loader and serves as a golden-stimulus source for imm_gen and decoder benches.

Parameters:
FIFO_DEPTH, 2, output buffer entries (power of two, >=2)
CNT_W, 16, width of encode/error counters

Ports:
clk_w_i  input  1  clock, rising edge
rst_n_w_i  input  1  reset, asynchronous, active-low
flush_w_i  input  1  synchronous FIFO clear
in_valid_w_i  input  1  input fields valid
in_ready_w_o  output  1  encoder can accept
type_w_i  input  3  format: R=0, J=1, U=2, S=3, B=4, I=5
opcode_w_i  input  7  opcode
rd_w_i  input  5  destination reg
rs1_w_i  input  5  source reg 1
rs2_w_i  input  5  source reg 2
funct3_w_i  input  3  funct3
funct7_w_i  input  7  funct7 (R only)
imm_w_i  input  32  full immediate value (byte offset / U value)
out_valid_w_o  output  1  instr_w_o valid
out_ready_w_i  input  1  consumer accepts
instr_w_o  output  32  encoded instruction
err_w_o  output  1  entry had a range/alignment/type error
enc_count_w_o  output  CNT_W  accepted-entry count, saturating
err_count_w_o  output  CNT_W  errored-entry count, saturating

Behaviour:
- Clocking: one clock, clk_w_i; reset asynchronous, active-low (rst_n_w_i).
- Reset: FIFO empty. out_valid_w_o=0, instr_w_o=0, err_w_o=0, counters=0. in_ready_w_o=0 while rst_n_w_i low, 1 from the first edge after release.
- Push: in_valid_w_i & in_ready_w_o at a rising edge. in_ready_w_o = (count < FIFO_DEPTH) & ~flush_w_i. It depends only on state, never on out_ready_w_i, so there is no push-on-full, even with a simultaneous pop.
- Pop: out_valid_w_o & out_ready_w_i. instr_w_o/err_w_o show the head entry and stay stable while valid & ~ready.
- Latency: an entry pushed at edge N is visible at out_valid_w_o after edge N when the FIFO was empty. There is no combinational in→out path.
- Simultaneous push and pop, count < DEPTH: both happen, count unchanged, order preserved. Pointers wrap modulo FIFO_DEPTH.
- Flush: empties the FIFO next edge, drops any same-cycle push, holds counters.
- Reset mid-operation: all entries lost immediately (asynchronous).
- Encoding, combinational on inputs, registered into the FIFO:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Error rules (entry is still encoded from truncated bits; err stored with the entry):
  - I/S: imm not sign-representable in 12 bits (imm[31:11] not all equal).
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
  - type 6/7: entry becomes 32'h0000_0013 (NOP), err=1.
  - R: never errors.
- Counters: enc_count increments per push, err_count per errored push; both saturate at all-ones.

Decomposition:
- Shared header cpe_isa_defs: format type codes (R/J/U/S/B/I), NOP constant, opcode constants. The same header is used by imm_gen and its bench.
- One natural sub-module, sync_fifo (parameterized width/depth, 33-bit entries {err, instr}). Encoder and range check stay in instr_encoder.

Test Plan:
- I, opcode 0010011, rd=1, rs1=0, f3=0, imm=32'hFFFF_FFFF → instr 32'hFFF0_0093, err=0, valid one cycle after push.
- S, opcode 0100011, rs1=1, rs2=2, f3=010, imm=8 → 32'h0020_A423. U, opcode 0110111, rd=5, imm=32'h1234_5000 → 32'h1234_52B7.
- J, opcode 1101111, rd=1, imm=32'h800 → 32'h0010_00EF. B with imm=3 → err_w_o=1, err_count=1. I with imm=2048 → err=1. type=7 → 32'h0000_0013, err=1.
- Back-pressure: out_ready=0, push 3 entries → in_ready drops after 2 and the third is held. Release out_ready → entries appear in order, instr stable while stalled, enc_count=3.
- Push and pop in the same cycle at count=1 → count stays 1, no loss or duplication over 10,000 random entries checked against an imm_gen round-trip model.
- Assert rst_n mid-stream with 2 entries queued → out_valid=0 and counters=0 immediately. Flush with 2 queued → empty next edge, counters held.
